// File: rtl/addsub_issue_q.sv
// Operand issue queue for the 36-bit add/sub datapath: a FIFO of {a, b, add} requests
// feeding a combinational datapath, with a registered valid/ready result stage and zero flag.
module addsub_issue_q #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic                     in_add,
  output logic [WIDTH-1:0]         op_a,
  output logic [WIDTH-1:0]         op_b,
  output logic                     op_add,
  input  logic [WIDTH-1:0]         sum_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_sum,
  output logic                     out_zero,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1'b1);

  function automatic logic is_zero(input logic [WIDTH-1:0] v);
    return (v == {WIDTH{1'b0}});
  endfunction

  logic [WIDTH-1:0] mem_a_q [DEPTH];
  logic [WIDTH-1:0] mem_b_q [DEPTH];
  logic [DEPTH-1:0] mem_add_q;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_zero_q, out_zero_d;

  logic push_s;
  logic capture_s;
  logic nonempty_s;

  assign nonempty_s = (count_q != {CW{1'b0}});
  assign push_s     = in_valid & in_ready_q;
  assign capture_s  = nonempty_s & (~out_valid_q | out_ready);

  // Occupancy and pointer bookkeeping; in_ready is registered from next occupancy only.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (capture_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, capture_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    in_ready_d = (count_d < DEPTH_C);
  end

  // Result stage: capture has priority over drain; data holds when draining.
  always_comb begin
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_zero_d  = out_zero_q;
    if (capture_s) begin
      out_valid_d = 1'b1;
      out_sum_d   = sum_i;
      out_zero_d  = is_zero(sum_i);
    end else if (out_valid_q & out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Head entry drive; an empty queue presents a harmless 0 + 0.
  always_comb begin
    op_a   = {WIDTH{1'b0}};
    op_b   = {WIDTH{1'b0}};
    op_add = 1'b1;
    if (nonempty_s) begin
      op_a   = mem_a_q[rd_ptr_q];
      op_b   = mem_b_q[rd_ptr_q];
      op_add = mem_add_q[rd_ptr_q];
    end else begin
      op_a   = {WIDTH{1'b0}};
      op_b   = {WIDTH{1'b0}};
      op_add = 1'b1;
    end
  end

  // Queue storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_a_q[i] <= {WIDTH{1'b0}};
        mem_b_q[i] <= {WIDTH{1'b0}};
      end
      mem_add_q <= {DEPTH{1'b0}};
    end else if (push_s) begin
      mem_a_q[wr_ptr_q]   <= in_a;
      mem_b_q[wr_ptr_q]   <= in_b;
      mem_add_q[wr_ptr_q] <= in_add;
    end
  end

  // Control and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      count_q     <= {CW{1'b0}};
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= {WIDTH{1'b0}};
      out_zero_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_zero_q  <= out_zero_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_zero  = out_zero_q;
  assign count     = count_q;

endmodule

// File: tb/tb_addsub_issue_q.sv
// Self-checking bench for addsub_issue_q: directed cases plus randomized traffic
// scored against a FIFO-of-results reference model.
module tb_addsub_issue_q;

  localparam int W = 36;
  localparam int D = 4;
  localparam longint unsigned MOD = 64'h0000_0010_0000_0000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_add;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_add;
  logic [W-1:0] sum_i;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_zero;
  logic [2:0]   count;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  // Combinational add/sub datapath environment.
  assign sum_i = op_add ? (op_a + op_b) : (op_a - op_b);

  addsub_issue_q #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_add(in_add),
    .op_a(op_a), .op_b(op_b), .op_add(op_add),
    .sum_i(sum_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_zero(out_zero),
    .count(count)
  );

  function automatic logic [W-1:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic add);
    longint unsigned ua, ub, r;
    ua = longint'(a);
    ub = longint'(b);
    if (add) r = (ua + ub) % MOD;
    else     r = (ua + MOD - ub) % MOD;
    return r[W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: score handshakes just before the edge, return #1 after it.
  task automatic cycle();
    @(negedge clk);
    chk("occupancy", 64'(count) + 64'(out_valid), 64'(exp_q.size()));
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 64'(out_valid), 64'd0);
      end else begin
        chk("sum", 64'(out_sum), 64'(exp_q[0]));
        chk("zero", 64'(out_zero), 64'(exp_q[0] == {W{1'b0}}));
        void'(exp_q.pop_front());
      end
    end
    if (in_valid === 1'b1 && in_ready === 1'b1)
      exp_q.push_back(ref_res(in_a, in_b, in_add));
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic add, input logic [W-1:0] exp_sum, input logic exp_zero);
    in_a = a; in_b = b; in_add = add; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk({tag, "_valid_lat0"}, 64'(out_valid), 64'd0);
    chk({tag, "_count"}, 64'(count), 64'd1);
    cycle();
    chk({tag, "_valid_lat1"}, 64'(out_valid), 64'd1);
    chk({tag, "_sum"}, 64'(out_sum), 64'(exp_sum));
    chk({tag, "_zero"}, 64'(out_zero), 64'(exp_zero));
    cycle();
    chk({tag, "_drain"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int acc;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_add = 1'b0; out_ready = 1'b0;
    cycle(); cycle();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_out_zero", 64'(out_zero), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_op_add", 64'(op_add), 64'd1);
    rst_n = 1'b1;
    cycle();
    chk("rel_in_ready", 64'(in_ready), 64'd1);

    directed("t1", 36'd5, 36'd7, 1'b1, 36'd12, 1'b0);
    directed("t2", 36'd3, 36'd5, 1'b0, 36'hF_FFFF_FFFE, 1'b0);
    directed("t3", 36'h123, 36'h123, 1'b0, 36'd0, 1'b1);
    directed("t4", 36'hF_FFFF_FFFF, 36'd1, 1'b1, 36'd0, 1'b1);

    // Back-pressure: 7 offered, DEPTH + 1 accepted.
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = (acc < 7);
      in_a = W'(100 + acc); in_b = W'(acc); in_add = acc[0];
      if (in_valid && in_ready) acc++;
      cycle();
    end
    in_valid = 1'b0;
    chk("bp_accepted", 64'(acc), 64'd5);
    chk("bp_count", 64'(count), 64'd4);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_release_valid", 64'(out_valid), 64'd1);
      cycle();
    end
    chk("bp_release_done", 64'(out_valid), 64'd0);

    // Back-to-back stream with out_ready high, then reset mid-stream.
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b1;
      in_a = W'({$urandom(), $urandom()}); in_b = W'({$urandom(), $urandom()});
      in_add = 1'($urandom_range(0, 1));
      if (i >= 2) chk("stream_in_ready", 64'(in_ready), 64'd1);
      cycle();
      if (i >= 1) chk("stream_no_bubble", 64'(out_valid), 64'd1);
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_count", 64'(count), 64'd0);
    exp_q.delete();
    in_valid = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_empty", 64'(out_valid), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_a = W'({$urandom(), $urandom()});
      in_b = W'({$urandom(), $urandom()});
      in_add = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        in_b = in_a; in_add = 1'b0;
      end
      cycle();
      chk("rand_ready_rule", 64'(in_ready), 64'(count < 3'd4));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) cycle();
    chk("rand_drained", 64'(exp_q.size()), 64'd0);
    chk("rand_final_valid", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
